seg7_step_decoder: RTL and testbench
====================================

// Module: seg7_step_decoder
// PURPOSE
//  Receive-side counterpart of the up/down counter's 7-segment output.
//  Samples display[6:0], filters glitches, decodes the pattern to a BCD digit and classifies each accepted change as up-step, down-step, jump or illegal.
//  Used as an on-chip checker/monitor of the counter's display bus and as a reusable 7-seg receiver in benches.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive identical samples required before a pattern is accepted (>=1)
//  CNT_W          8   width of the saturating event counters
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  rst_n         in   1      asynchronous active-low reset
//  display       in   7      segments {g,f,e,d,c,b,a}, active-high
//  digit         out  4      last accepted digit (0-9)
//  digit_valid   out  1      1-cycle pulse when a new pattern is accepted
//  step_up       out  1      1-cycle pulse: accepted digit == (prev+1) mod 10
//  step_down     out  1      1-cycle pulse: accepted digit == (prev+9) mod 10
//  jump          out  1      1-cycle pulse: legal digit, but neither +1 nor -1 from prev
//  illegal       out  1      1-cycle pulse: accepted pattern not in the 0-9 table
//  locked        out  1      high once a first legal digit has been accepted
//  up_cnt        out  CNT_W  saturating count of step_up pulses
//  down_cnt      out  CNT_W  saturating count of step_down pulses
//  err_cnt       out  CNT_W  saturating count of jump + illegal pulses
// BEHAVIOUR
//  Reset: all outputs 0; FSM = UNLOCKED; stability counter 0; sample register 7'h00.
//  Decode table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex). Any other pattern is illegal.
//  Input is registered once (s0). A stability counter increments while s0 equals the previous s0 and reloads to 1 on any change.
//  A pattern is accepted on the cycle the counter reaches STABLE_CYCLES and differs from the last accepted pattern.
//  Re-acceptance of the same pattern never pulses.
//  Latency: display change -> digit_valid = STABLE_CYCLES+1 clocks.
//  All pulse outputs and digit update in the same cycle.
//  At most one of step_up/step_down/jump/illegal pulses per acceptance.
//  FSM:
//   - UNLOCKED: first legal accept -> digit_valid, locked=1, no step/jump pulse -> LOCKED. An illegal accept pulses illegal and stays UNLOCKED.
//   - LOCKED: legal accept -> classify against prev digit, update digit. An illegal accept pulses illegal and leaves digit unchanged -> FAULT.
//   - FAULT: locked stays 1. The next legal accept pulses digit_valid only (no step/jump) and re-baselines -> LOCKED.
//  Wrap: 9->0 is step_up and 0->9 is step_down.
//  Counters saturate at 2**CNT_W-1 (no wrap). err_cnt increments by 1 even when saturated-adjacent.
//  Glitch shorter than STABLE_CYCLES: no output activity, and the last accepted pattern is retained.
//  Reset asserted mid-operation: immediate clear to reset values. First acceptance after release behaves as UNLOCKED.
//  STABLE_CYCLES=1: accept on the first sample that differs from the last accepted one.
// STRUCTURE
//  Package seg7_pkg:
//   - SEG_0..SEG_9 localparams
//   - function seg7_to_bcd(input [6:0]) -> {legal, [3:0] digit}
//   - typedef enum {UNLOCKED, LOCKED, FAULT} seg7_rx_state_e
//  Sub-module sat_counter #(W) with inc and rst_n, instantiated 3x for up/down/err.
//  Filter, FSM and classification stay in the top module.
// TESTING
//  1. Reset, drive 3F held 10 clk -> digit_valid once at clk 5 after change, digit=0, locked=1, no step pulse.
//  2. From 0, drive 06,5B,4F each held 6 clk -> 3x step_up, up_cnt=3, digit=3.
//  3. From 9 (6F) drive 3F, then 6F -> step_up then step_down; up_cnt=1, down_cnt=1.
//  4. From 2, drive 7F (8) held -> jump pulse, err_cnt=1, digit=8.
//  5. From 5, drive 7'h49 held -> illegal, digit stays 5 (FAULT); then 66 -> digit_valid only, then 6D -> step_up.
//  6. 2-clk glitch 06 inside steady 3F -> no pulses; rst_n low mid-hold -> all outputs 0 asynchronously; CNT_W=2 with 5 up-steps -> up_cnt=3.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the 7-segment receive path:
//   - SEG_0..SEG_9 : segment patterns {g,f,e,d,c,b,a}, active-high
//   - seg7_to_bcd  : pattern -> {legal, digit[3:0]}
//   - seg7_rx_state_e : receiver FSM states
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } seg7_rx_state_e;

  // Returns {legal, digit}; any pattern outside the table is {0, 0}.
  function automatic logic [4:0] seg7_to_bcd(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      SEG_0:   res = {1'b1, 4'd0};
      SEG_1:   res = {1'b1, 4'd1};
      SEG_2:   res = {1'b1, 4'd2};
      SEG_3:   res = {1'b1, 4'd3};
      SEG_4:   res = {1'b1, 4'd4};
      SEG_5:   res = {1'b1, 4'd5};
      SEG_6:   res = {1'b1, 4'd6};
      SEG_7:   res = {1'b1, 4'd7};
      SEG_8:   res = {1'b1, 4'd8};
      SEG_9:   res = {1'b1, 4'd9};
      default: res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_step_decoder_sat_counter.sv
// sat_counter
//   Event counter that holds at all-ones instead of wrapping.
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears to 0)
//   inc   : add one this cycle
//   cnt   : current count (registered)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] cnt_r;

  // Count inc pulses, holding at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/seg7_step_decoder.sv
// seg7_step_decoder
//   Samples a 7-segment bus, filters glitches, decodes to BCD and classifies
//   every accepted change as up-step, down-step, jump or illegal.
//   clk, rst_n      : clock, asynchronous active-low reset
//   display[6:0]    : segments {g,f,e,d,c,b,a}, active-high
//   digit[3:0]      : last accepted legal digit
//   digit_valid     : pulse on acceptance of a legal pattern
//   step_up/step_down/jump/illegal : one-cycle classification pulses
//   locked          : set once a first legal digit has been accepted
//   up_cnt/down_cnt/err_cnt : saturating event counters
module seg7_step_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       display,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             jump,
  output logic             illegal,
  output logic             locked,
  output logic [CNT_W-1:0] up_cnt,
  output logic [CNT_W-1:0] down_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int              STAB_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

  // Input filter state
  logic [6:0]        s0_r;
  logic [STAB_W-1:0] stab_r;
  // Last accepted pattern (legal or not) so a held pattern never re-pulses
  logic [6:0]        last_pat_r;
  logic [6:0]        last_pat_s;

  seg7_rx_state_e state_r, state_s;

  logic [3:0] digit_r,  digit_s;
  logic       valid_r,  valid_s;
  logic       up_r,     up_s;
  logic       down_r,   down_s;
  logic       jump_r,   jump_s;
  logic       ill_r,    ill_s;
  logic       locked_r, locked_s;

  logic       accept_s;
  logic [4:0] dec_s;
  logic [3:0] next_up_s;
  logic [3:0] next_down_s;

  // Sample the bus and count how long the sample has stayed unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_r   <= 7'h00;
      stab_r <= {STAB_W{1'b0}};
    end else begin
      s0_r <= display;
      if (display != s0_r) begin
        stab_r <= STAB_ONE;
      end else if (stab_r != STAB_MAX) begin
        stab_r <= stab_r + STAB_ONE;
      end else begin
        stab_r <= stab_r;
      end
    end
  end

  // Neighbours of the current digit, with 9<->0 wrap
  always_comb begin
    next_up_s   = (digit_r == 4'd9) ? 4'd0 : (digit_r + 4'd1);
    next_down_s = (digit_r == 4'd0) ? 4'd9 : (digit_r - 4'd1);
  end

  // Acceptance, FSM next state and classification pulses
  always_comb begin
    state_s    = state_r;
    digit_s    = digit_r;
    last_pat_s = last_pat_r;
    locked_s   = locked_r;
    valid_s    = 1'b0;
    up_s       = 1'b0;
    down_s     = 1'b0;
    jump_s     = 1'b0;
    ill_s      = 1'b0;
    dec_s      = seg7_to_bcd(s0_r);
    accept_s   = (stab_r == STAB_MAX) && (s0_r != last_pat_r);

    if (accept_s) begin
      last_pat_s = s0_r;
      if (dec_s[4]) begin
        valid_s  = 1'b1;
        digit_s  = dec_s[3:0];
        locked_s = 1'b1;
        case (state_r)
          // Only a LOCKED receiver has a trusted baseline to classify against
          LOCKED: begin
            if (dec_s[3:0] == next_up_s) begin
              up_s = 1'b1;
            end else if (dec_s[3:0] == next_down_s) begin
              down_s = 1'b1;
            end else begin
              jump_s = 1'b1;
            end
            state_s = LOCKED;
          end
          UNLOCKED: state_s = LOCKED;
          FAULT:    state_s = LOCKED;
          default:  state_s = UNLOCKED;
        endcase
      end else begin
        ill_s = 1'b1;
        case (state_r)
          UNLOCKED: state_s = UNLOCKED;
          LOCKED:   state_s = FAULT;
          FAULT:    state_s = FAULT;
          default:  state_s = UNLOCKED;
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // FSM state, last pattern and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= UNLOCKED;
      last_pat_r <= 7'h00;
      digit_r    <= 4'd0;
      valid_r    <= 1'b0;
      up_r       <= 1'b0;
      down_r     <= 1'b0;
      jump_r     <= 1'b0;
      ill_r      <= 1'b0;
      locked_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      last_pat_r <= last_pat_s;
      digit_r    <= digit_s;
      valid_r    <= valid_s;
      up_r       <= up_s;
      down_r     <= down_s;
      jump_r     <= jump_s;
      ill_r      <= ill_s;
      locked_r   <= locked_s;
    end
  end

  // Counters take the pre-register pulses so they update with the pulse
  sat_counter #(.W(CNT_W)) u_up_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (up_s),
    .cnt   (up_cnt)
  );

  sat_counter #(.W(CNT_W)) u_down_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (down_s),
    .cnt   (down_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (jump_s | ill_s),
    .cnt   (err_cnt)
  );

  assign digit       = digit_r;
  assign digit_valid = valid_r;
  assign step_up     = up_r;
  assign step_down   = down_r;
  assign jump        = jump_r;
  assign illegal     = ill_r;
  assign locked      = locked_r;

endmodule

// File: tb/tb_seg7_step_decoder.sv
module tb_seg7_step_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] display;
  logic [6:0] display2;

  logic [3:0] digit;
  logic       digit_valid, step_up, step_down, jump, illegal, locked;
  logic [7:0] up_cnt, down_cnt, err_cnt;

  logic [3:0] digit2;
  logic       digit_valid2, step_up2, step_down2, jump2, illegal2, locked2;
  logic [1:0] up_cnt2, down_cnt2, err_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] pat;
    logic [3:0] dig;
    logic [4:0] pulses;  // {valid, up, down, jump, illegal}
    logic       lk;
    logic [7:0] uc;
    logic [7:0] dc;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs [15];

  seg7_step_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .display(display),
    .digit(digit), .digit_valid(digit_valid), .step_up(step_up),
    .step_down(step_down), .jump(jump), .illegal(illegal), .locked(locked),
    .up_cnt(up_cnt), .down_cnt(down_cnt), .err_cnt(err_cnt)
  );

  seg7_step_decoder #(.STABLE_CYCLES(1), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .display(display2),
    .digit(digit2), .digit_valid(digit_valid2), .step_up(step_up2),
    .step_down(step_down2), .jump(jump2), .illegal(illegal2), .locked(locked2),
    .up_cnt(up_cnt2), .down_cnt(down_cnt2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] pat, input logic [3:0] dig,
                              input logic [4:0] pulses, input logic lk,
                              input logic [7:0] uc, input logic [7:0] dc,
                              input logic [7:0] ec);
    vec_t v;
    v.pat = pat; v.dig = dig; v.pulses = pulses; v.lk = lk;
    v.uc = uc; v.dc = dc; v.ec = ec;
    return v;
  endfunction

  function automatic logic [4:0] main_pulses();
    return {digit_valid, step_up, step_down, jump, illegal};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a pattern, check latency, the acceptance cycle and that pulses last one cycle
  task automatic apply(input vec_t v, input int idx);
    display = v.pat;
    tick(4);
    chk($sformatf("v%0d_early_pulse", idx), {27'd0, main_pulses()}, 32'd0);
    tick(1);
    chk($sformatf("v%0d_pulses", idx), {27'd0, main_pulses()}, {27'd0, v.pulses});
    chk($sformatf("v%0d_digit", idx), {28'd0, digit}, {28'd0, v.dig});
    chk($sformatf("v%0d_locked", idx), {31'd0, locked}, {31'd0, v.lk});
    chk($sformatf("v%0d_cnts", idx), {8'd0, up_cnt, down_cnt, err_cnt},
        {8'd0, v.uc, v.dc, v.ec});
    tick(1);
    chk($sformatf("v%0d_pulse_end", idx), {27'd0, main_pulses()}, 32'd0);
  endtask

  initial begin
    // {pat, digit, {valid,up,down,jump,illegal}, locked, up, down, err}
    vecs[0]  = mk(7'h3F, 4'd0, 5'b10000, 1'b1, 8'd0, 8'd0, 8'd0);
    vecs[1]  = mk(7'h06, 4'd1, 5'b11000, 1'b1, 8'd1, 8'd0, 8'd0);
    vecs[2]  = mk(7'h5B, 4'd2, 5'b11000, 1'b1, 8'd2, 8'd0, 8'd0);
    vecs[3]  = mk(7'h4F, 4'd3, 5'b11000, 1'b1, 8'd3, 8'd0, 8'd0);
    vecs[4]  = mk(7'h6F, 4'd9, 5'b10010, 1'b1, 8'd3, 8'd0, 8'd1);
    vecs[5]  = mk(7'h3F, 4'd0, 5'b11000, 1'b1, 8'd4, 8'd0, 8'd1);
    vecs[6]  = mk(7'h6F, 4'd9, 5'b10100, 1'b1, 8'd4, 8'd1, 8'd1);
    vecs[7]  = mk(7'h5B, 4'd2, 5'b10010, 1'b1, 8'd4, 8'd1, 8'd2);
    vecs[8]  = mk(7'h7F, 4'd8, 5'b10010, 1'b1, 8'd4, 8'd1, 8'd3);
    vecs[9]  = mk(7'h6D, 4'd5, 5'b10010, 1'b1, 8'd4, 8'd1, 8'd4);
    vecs[10] = mk(7'h49, 4'd5, 5'b00001, 1'b1, 8'd4, 8'd1, 8'd5);
    vecs[11] = mk(7'h66, 4'd4, 5'b10000, 1'b1, 8'd4, 8'd1, 8'd5);
    vecs[12] = mk(7'h6D, 4'd5, 5'b11000, 1'b1, 8'd5, 8'd1, 8'd5);
    vecs[13] = mk(7'h66, 4'd4, 5'b10100, 1'b1, 8'd5, 8'd2, 8'd5);
    vecs[14] = mk(7'h3F, 4'd0, 5'b10010, 1'b1, 8'd5, 8'd2, 8'd6);

    rst_n    = 1'b0;
    display  = 7'h00;
    display2 = 7'h00;
    tick(2);
    chk("reset_outputs",
        {4'd0, digit, main_pulses(), locked, up_cnt, down_cnt},
        32'd0);
    chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_no_pulse", {27'd0, main_pulses()}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i], i);
    end

    // Two-cycle glitch inside a steady 0 must leave no trace
    display = 7'h06;
    tick(2);
    display = 7'h3F;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk($sformatf("glitch_c%0d", i), {27'd0, main_pulses()}, 32'd0);
    end
    chk("glitch_digit", {28'd0, digit}, 32'd0);
    chk("glitch_cnts", {8'd0, up_cnt, down_cnt, err_cnt}, {8'd0, 8'd5, 8'd2, 8'd6});

    // Asynchronous reset mid-hold clears immediately, between clock edges
    display = 7'h5B;
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs",
        {4'd0, digit, main_pulses(), locked, up_cnt, down_cnt},
        32'd0);
    chk("async_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    display = 7'h49;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(5);
    chk("unlocked_illegal_pulses", {27'd0, main_pulses()}, 32'd1);
    chk("unlocked_illegal_locked", {31'd0, locked}, 32'd0);
    chk("unlocked_illegal_err", {24'd0, err_cnt}, 32'd1);
    tick(1);
    apply(mk(7'h3F, 4'd0, 5'b10000, 1'b1, 8'd0, 8'd0, 8'd1), 100);

    // STABLE_CYCLES=1 / CNT_W=2 instance: 2-clock latency and saturation at 3
    display2 = 7'h3F;
    tick(1);
    chk("small_early", {31'd0, digit_valid2}, 32'd0);
    tick(1);
    chk("small_first", {26'd0, digit_valid2, step_up2, locked2, digit2[2:0]},
        {26'd0, 1'b1, 1'b0, 1'b1, 3'd0});
    tick(1);
    begin
      logic [6:0] ups [5];
      ups[0] = 7'h06; ups[1] = 7'h5B; ups[2] = 7'h4F; ups[3] = 7'h66; ups[4] = 7'h6D;
      for (int i = 0; i < 5; i++) begin
        display2 = ups[i];
        tick(1);
        chk($sformatf("small_up%0d_early", i), {31'd0, step_up2}, 32'd0);
        tick(1);
        chk($sformatf("small_up%0d_pulse", i), {31'd0, step_up2}, 32'd1);
        chk($sformatf("small_up%0d_digit", i), {28'd0, digit2}, i + 1);
        chk($sformatf("small_up%0d_cnt", i), {30'd0, up_cnt2}, (i + 1 > 3) ? 3 : i + 1);
        tick(1);
        chk($sformatf("small_up%0d_hold", i), {31'd0, step_up2}, 32'd0);
      end
    end
    chk("small_other_cnts", {28'd0, down_cnt2, err_cnt2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
